// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, and holds the IR for control.
// Resolves the next PC from the control decode (jr/J/branch) one cycle after issuing each instruction.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Beq,
    input  logic        Bne,
    input  logic        J,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        Z,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        ir_valid,
    output logic        fetch_err
);

    localparam int unsigned CNT_W  = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [31:0] NOP_IR = 32'hFC00_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_RESOLVE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               cap_q, cap_d;
    logic               br_taken;
    logic [31:0]        br_off;
    logic               unused_jr_lsbs;

    assign br_taken       = (Beq & Z) | (Bne & ~Z);
    assign br_off         = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign unused_jr_lsbs = ^jr_target[1:0];

    // Next-state, next-PC and IR capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cap_d   = cap_q;
        case (state_q)
            S_IDLE: begin
                if (!stall) state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack taken while stalled is remembered so the stage advances on release
                if (imem_ack) begin
                    ir_d  = imem_rdata;
                    cap_d = 1'b1;
                end
                if (!stall) begin
                    if (imem_ack || cap_q) begin
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                        cap_d   = 1'b0;
                    end else if (cnt_q == CNT_W'(IMEM_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        ir_d    = NOP_IR;
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (!stall) state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (!stall) begin
                    if (jr_en)         pc_d = {jr_target[31:2], 2'b00};
                    else if (J)        pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                    else if (br_taken) pc_d = pc_plus4 + br_off;
                    else               pc_d = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_IR;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
        end
    end

    // Stall masks the issue pulse so control sees exactly one pulse per instruction
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign ir        = ir_q;
    assign opcode    = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign ir_valid  = (state_q == S_ISSUE) && !stall;
    assign fetch_err = err_q;

endmodule
